// File: rtl/multi_key_typematic_decoder.sv
// multi_key_typematic_decoder: tracks NUM_KEYS PS/2 key codes with edge, toggle and auto-repeat outputs
// Ports: clk/resetN (async active-low); keyCode/make/brakee from the keyboard interface;
// repeatEnable gates the typematic engine; per-key keyIsPressed, keyRisingEdgePulse,
// keyFallingEdgePulse, keyToggle and keyRepeatPulse; anyKeyPressed; lastKeyIndex/lastKeyValid.
module multi_key_typematic_decoder #(
  parameter int NUM_KEYS = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h172, 9'h174, 9'h16B, 9'h175},
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  localparam int IDXW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [8:0]          keyCode,
  input  logic                make,
  input  logic                brakee,
  input  logic                repeatEnable,
  output logic [NUM_KEYS-1:0] keyIsPressed,
  output logic [NUM_KEYS-1:0] keyRisingEdgePulse,
  output logic [NUM_KEYS-1:0] keyFallingEdgePulse,
  output logic [NUM_KEYS-1:0] keyToggle,
  output logic [NUM_KEYS-1:0] keyRepeatPulse,
  output logic                anyKeyPressed,
  output logic [IDXW-1:0]     lastKeyIndex,
  output logic                lastKeyValid
);
  localparam int MAXC = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNTW = $clog2(MAXC);
  localparam logic [CNTW-1:0] DELAY_LAST = CNTW'(REPEAT_DELAY - 1);
  localparam logic [CNTW-1:0] PERIOD_LAST = CNTW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} stateT;

  stateT state, stateNext;
  logic [CNTW-1:0] cnt, cntNext;
  logic [NUM_KEYS-1:0] pressed, pressedNext, pressedD, rise;
  logic [IDXW-1:0] riseIdx;
  logic atTerm, trackedPressed;

  assign rise = pressed & ~pressedD;
  assign keyIsPressed = pressed;
  assign keyRisingEdgePulse = rise;
  assign keyFallingEdgePulse = ~pressed & pressedD;
  assign anyKeyPressed = |pressed;
  // The tracked key is always the last pressed one: a rise with repeatEnable low aborts the FSM anyway.
  assign trackedPressed = pressed[lastKeyIndex];
  assign atTerm = (state == DELAY && cnt == DELAY_LAST) || (state == REPEAT && cnt == PERIOD_LAST);
  assign keyRepeatPulse = NUM_KEYS'(atTerm && trackedPressed && repeatEnable) << lastKeyIndex;

  // Release wins over press when both strobes arrive together; duplicate codes update every match.
  always_comb begin
    pressedNext = pressed;
    for (int i = 0; i < NUM_KEYS; i++)
      if (keyCode == KEY_CODES[9*i +: 9]) pressedNext[i] = brakee ? 1'b0 : make ? 1'b1 : pressed[i];
  end

  // Lowest rising index wins: scan downward so the last hit is the smallest.
  always_comb begin
    riseIdx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (rise[i]) riseIdx = IDXW'(i);
  end

  always_comb begin
    stateNext = state;
    cntNext = cnt;
    if (|rise && repeatEnable) begin
      stateNext = DELAY;
      cntNext = '0;
    end else if (state != IDLE && !(trackedPressed && repeatEnable)) begin
      stateNext = IDLE;
      cntNext = '0;
    end else if (state == DELAY) begin
      stateNext = atTerm ? REPEAT : DELAY;
      cntNext = atTerm ? '0 : cnt + 1'b1;
    end else if (state == REPEAT) begin
      cntNext = atTerm ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pressed <= '0;
      pressedD <= '0;
      keyToggle <= '0;
      lastKeyIndex <= '0;
      lastKeyValid <= 1'b0;
      state <= IDLE;
      cnt <= '0;
    end else begin
      pressed <= pressedNext;
      pressedD <= pressed;
      keyToggle <= keyToggle ^ rise;
      if (|rise) begin
        lastKeyIndex <= riseIdx;
        lastKeyValid <= 1'b1;
      end
      state <= stateNext;
      cnt <= cntNext;
    end
  end
endmodule

// File: tb/tb_multi_key_typematic_decoder.sv
// tb_multi_key_typematic_decoder: scoreboard bench for the multi-key typematic decoder
module tb_multi_key_typematic_decoder;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [8:0] keyCode = '0;
  logic make = 1'b0;
  logic brakee = 1'b0;
  logic repeatEnable = 1'b1;
  logic [3:0] keyIsPressed, keyRisingEdgePulse, keyFallingEdgePulse, keyToggle, keyRepeatPulse;
  logic anyKeyPressed, lastKeyValid;
  logic [1:0] lastKeyIndex;

  multi_key_typematic_decoder #(
    .NUM_KEYS(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .keyCode(keyCode),
    .make(make),
    .brakee(brakee),
    .repeatEnable(repeatEnable),
    .keyIsPressed(keyIsPressed),
    .keyRisingEdgePulse(keyRisingEdgePulse),
    .keyFallingEdgePulse(keyFallingEdgePulse),
    .keyToggle(keyToggle),
    .keyRepeatPulse(keyRepeatPulse),
    .anyKeyPressed(anyKeyPressed),
    .lastKeyIndex(lastKeyIndex),
    .lastKeyValid(lastKeyValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int sig;
    logic [7:0] val;
  } itemT;

  itemT sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  string sigNames [8] = '{"pressed", "rise", "fall", "toggle", "repeat", "lastIdx", "lastValid", "any"};

  function automatic logic [7:0] sigVal(int s);
    case (s)
      0: return 8'(keyIsPressed);
      1: return 8'(keyRisingEdgePulse);
      2: return 8'(keyFallingEdgePulse);
      3: return 8'(keyToggle);
      4: return 8'(keyRepeatPulse);
      5: return 8'(lastKeyIndex);
      6: return 8'(lastKeyValid);
      default: return 8'(anyKeyPressed);
    endcase
  endfunction

  function automatic void want(int c, int s, logic [7:0] v);
    sb.push_back('{c, s, v});
  endfunction

  // Sample this cycle's expectations on the falling edge, then advance to the next cycle.
  task automatic step();
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [7:0] act;
        act = sigVal(sb[i].sig);
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cycle %0d: got %0h expected %0h", sigNames[sb[i].sig], cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic runTo(int c);
    while (cyc < c) step();
  endtask

  task automatic pressKey(logic [8:0] code);
    keyCode = code;
    make = 1'b1;
    step();
    make = 1'b0;
  endtask

  task automatic releaseKey(logic [8:0] code);
    keyCode = code;
    brakee = 1'b1;
    step();
    brakee = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (sigVal(s) !== 8'h00) begin
        errors++;
        $display("FAIL reset_%s: got %0h expected 0", sigNames[s], sigVal(s));
      end
    end
    @(posedge clk);
    #1;
    resetN = 1'b1;
    cyc = 0;
    for (int s = 0; s < 8; s++) want(1, s, 8'h00);
  endtask

  task automatic test_press();
    want(10, 0, 8'h0); want(11, 0, 8'h1); want(12, 0, 8'h1);
    want(10, 1, 8'h0); want(11, 1, 8'h1); want(12, 1, 8'h0);
    want(11, 3, 8'h0); want(12, 3, 8'h1);
    want(11, 6, 8'h0); want(12, 6, 8'h1); want(12, 5, 8'h0);
    want(11, 7, 8'h1);
    runTo(10);
    pressKey(9'h175);
  endtask

  task automatic test_repeat();
    for (int c = 12; c <= 28; c++) want(c, 4, (c == 19 || c == 22 || c == 25) ? 8'h1 : 8'h0);
    want(25, 2, 8'h0); want(26, 2, 8'h1); want(27, 2, 8'h0);
    want(26, 0, 8'h0); want(26, 7, 8'h0);
    runTo(25);
    releaseKey(9'h175);
    runTo(29);
  endtask

  task automatic test_preempt();
    int s;
    s = cyc;
    for (int c = s + 2; c <= s + 34; c++)
      want(c, 4, (c == s + 10 || c == s + 13) ? 8'h1 : (c == s + 23 || c == s + 26 || c == s + 29) ? 8'h2 : 8'h0);
    want(s + 15, 1, 8'h2); want(s + 16, 5, 8'h1); want(s + 16, 3, 8'h2);
    want(s + 19, 0, 8'h2); want(s + 19, 2, 8'h1); want(s + 31, 0, 8'h0);
    runTo(s + 1);
    pressKey(9'h175);
    runTo(s + 14);
    pressKey(9'h16B);
    runTo(s + 18);
    releaseKey(9'h175);
    runTo(s + 30);
    releaseKey(9'h16B);
    runTo(s + 35);
  endtask

  task automatic test_collision();
    int s;
    s = cyc;
    want(s + 2, 0, 8'h0); want(s + 2, 1, 8'h0);
    want(s + 5, 1, 8'h8); want(s + 6, 3, 8'hA); want(s + 6, 5, 8'h3);
    want(s + 8, 1, 8'h0); want(s + 10, 1, 8'h0); want(s + 11, 3, 8'hA); want(s + 11, 0, 8'h8);
    for (int c = s + 6; c <= s + 16; c++) want(c, 4, c == s + 13 ? 8'h8 : 8'h0);
    runTo(s + 1);
    keyCode = 9'h174;
    make = 1'b1;
    brakee = 1'b1;
    step();
    make = 1'b0;
    brakee = 1'b0;
    runTo(s + 4);
    pressKey(9'h172);
    runTo(s + 7);
    pressKey(9'h172);
    runTo(s + 9);
    pressKey(9'h172);
    runTo(s + 14);
    releaseKey(9'h172);
    runTo(s + 17);
  endtask

  task automatic test_enable();
    int s;
    s = cyc;
    for (int c = s + 2; c <= s + 24; c++) want(c, 4, 8'h0);
    want(s + 3, 0, 8'h4); want(s + 20, 0, 8'h4); want(s + 3, 5, 8'h2);
    runTo(s + 1);
    pressKey(9'h174);
    runTo(s + 5);
    repeatEnable = 1'b0;
    runTo(s + 8);
    repeatEnable = 1'b1;
    runTo(s + 22);
    releaseKey(9'h174);
    runTo(s + 25);
  endtask

  task automatic test_async_reset();
    int s;
    s = cyc;
    want(s + 11, 4, 8'h2); want(s + 12, 0, 8'h3); want(s + 12, 5, 8'h1);
    runTo(s + 1);
    pressKey(9'h175);
    pressKey(9'h16B);
    runTo(s + 13);
    resetN = 1'b0;
    #2;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sigVal(k) !== 8'h00) begin
        errors++;
        $display("FAIL async_reset_%s: got %0h expected 0", sigNames[k], sigVal(k));
      end
    end
    #1;
    resetN = 1'b1;
    for (int c = s + 13; c <= s + 17; c++)
      for (int k = 0; k < 8; k++) want(c, k, 8'h0);
    want(s + 19, 0, 8'h4); want(s + 19, 1, 8'h4);
    want(s + 20, 5, 8'h2); want(s + 20, 6, 8'h1); want(s + 20, 3, 8'h4);
    runTo(s + 18);
    pressKey(9'h174);
    runTo(s + 22);
  endtask

  initial begin
    test_reset();
    test_press();
    test_repeat();
    test_preempt();
    test_collision();
    test_enable();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_key_typematic_decoder.md
# multi_key_typematic_decoder

Parametrised multi-key decoder for the PS/2 keyboard path: watches the `keyCode`/`make`/`brakee` stream from the keyboard interface and tracks up to `NUM_KEYS` configurable key codes in one block. For each key it provides the pressed level, rising- and falling-edge pulses, and a toggle bit. It adds a typematic (auto-repeat) engine that pulses the most recently pressed key at a programmable delay and rate. It feeds game and control logic that previously needed one single-key decoder per key.

## Interface
- `NUM_KEYS`, 4: number of tracked keys; must be at least 1.
- `KEY_CODES`, {9'h172, 9'h174, 9'h16B, 9'h175}: packed `NUM_KEYS*9` bits. Key i uses bits [9i+8:9i]. Default: key0 = up, key1 = left, key2 = right, key3 = down.
- `REPEAT_DELAY`, 25_000_000: cycles from rising pulse to first repeat pulse; must be at least 2.
- `REPEAT_PERIOD`, 5_000_000: cycles between later repeat pulses; must be at least 2.
- `clk` input 1: single clock, all logic rising-edge.
- `resetN` input 1: asynchronous, active-low reset.
- `keyCode` input 9: code from the keyboard interface; bit 8 set means extended (E0) code.
- `make` input 1: one-cycle strobe, key press for `keyCode`.
- `brakee` input 1: one-cycle strobe, key release for `keyCode`.
- `repeatEnable` input 1: level; 0 disables and aborts auto-repeat.
- `keyIsPressed` output NUM_KEYS: per-key pressed level.
- `keyRisingEdgePulse` output NUM_KEYS: one-cycle pulse on press.
- `keyFallingEdgePulse` output NUM_KEYS: one-cycle pulse on release.
- `keyToggle` output NUM_KEYS: flips on each press.
- `keyRepeatPulse` output NUM_KEYS: one-cycle typematic pulse.
- `anyKeyPressed` output 1: OR of `keyIsPressed`.
- `lastKeyIndex` output IDXW: index of the most recently pressed key. IDXW = max(1, $clog2(NUM_KEYS)).
- `lastKeyValid` output 1: set by the first press after reset; sticky.

## Operation
- Per key i, on a cycle where `keyCode == KEY_CODES[i]`:
  - `make` sets pressed.
  - `brakee` clears pressed.
  - If both are high, `brakee` wins.
- Non-matching codes are ignored. Duplicate table entries all update together.
- `keyIsPressed_d` is a one-cycle delayed copy of pressed.
  - Rise = pressed & ~pressed_d.
  - Fall = ~pressed & pressed_d.
  - Both are combinational from registers.
- Toggle register flips on the clock edge that ends a rise cycle.
- PS/2 typematic re-makes for an already pressed key are absorbed: no new rise, toggle or FSM restart.
- `lastKeyIndex` loads the index of the key whose rise is active. If several rise in the same cycle, the lowest index is loaded. `lastKeyValid` is set at the same time.
- Repeat FSM, with states IDLE, DELAY and REPEAT and one shared counter `cnt` of width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)):
  - Any rise with `repeatEnable = 1`: go to DELAY, `cnt <= 0`, track the new key. This applies from every state and overrides the release and abort rules below.
  - DELAY: `cnt` increments. At `cnt == REPEAT_DELAY-1`: pulse, `cnt <= 0`, go to REPEAT.
  - REPEAT: `cnt` increments. At `cnt == REPEAT_PERIOD-1`: pulse, `cnt <= 0`.
  - In DELAY or REPEAT, if the tracked key is not pressed or `repeatEnable = 0`: go to IDLE, `cnt <= 0`, and no pulse that cycle.
  - Releasing a non-tracked key has no effect on the FSM.
- `keyRepeatPulse[lastKeyIndex]` is combinational. It is high when the FSM is at a terminal count, the tracked key is pressed and `repeatEnable = 1`. All other bits are 0.

## Timing
- Reset (async assert): all pressed, delayed-pressed and toggle bits are 0. FSM is IDLE, `cnt = 0`, `lastKeyIndex = 0`, `lastKeyValid = 0`. Therefore every output is 0.
- `make` in cycle N:
  - `keyIsPressed` and `keyRisingEdgePulse` are high in cycle N+1.
  - `keyToggle` changes in cycle N+2.
  - `lastKeyIndex` is valid in cycle N+2.
- `brakee` in cycle M: `keyIsPressed` drops and `keyFallingEdgePulse` is high in cycle M+1.
- Repeat pulses (rise in cycle R):
  - First repeat pulse in cycle R+REPEAT_DELAY.
  - Then every REPEAT_PERIOD cycles while the key is held.
- Release in cycle M: no repeat pulse from cycle M+1 onward.
- Deasserting `resetN` mid-operation clears everything at once. There is no pulse on reset release.

## Test plan
Bench parameters: NUM_KEYS = 4, REPEAT_DELAY = 8, REPEAT_PERIOD = 3.
1. Reset, then `make` on 9'h175 at cycle 10:
   - `keyIsPressed` = 4'b0001 from cycle 11.
   - `keyRisingEdgePulse` = 4'b0001 only in cycle 11.
   - `keyToggle[0]` = 1 from cycle 12.
   - `lastKeyIndex` = 0 and `lastKeyValid` = 1.
2. Hold key 0 from test 1:
   - `keyRepeatPulse[0]` high in cycles 19, 22 and 25.
   - `brakee` at cycle 25 → `keyIsPressed[0]` = 0 and fall pulse in cycle 26; no repeat pulse at 28.
3. Press key1 (9'h16B) while key0 is held in REPEAT:
   - FSM restarts; repeat pulses on bit 1 only, first at rise + 8.
   - Releasing key0 meanwhile produces no change.
4. `make` and `brakee` together on 9'h174 → `keyIsPressed[2]` stays 0. Repeated `make` on a held key → a single rise and a single toggle.
5. Hold a key, drop `repeatEnable` mid-DELAY → no pulses; re-raising without a new press → still no pulses.
6. Assert `resetN` = 0 while two keys are held in REPEAT → all outputs 0 asynchronously; after release they stay 0 until a new `make`.
